// File: rtl/ca6_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ca6_seq_pkg
// Description : Shared types and default sizes for the Ca6 cosine sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ca6_seq_pkg;

  // Sequencer phases: wait for work, fire start, wait for done, hand back result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  localparam int DEF_XW      = 16;
  localparam int DEF_YW      = 8;
  localparam int DEF_CW      = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/ca6_cos_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ca6_req_fifo
// Description : Synchronous request FIFO holding packed {x, y} operands.
//               Pushes into a full FIFO are dropped even if a pop happens in
//               the same cycle, so the writer never has a bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module ca6_req_fifo
  import ca6_seq_pkg::*;
#(
  parameter int WIDTH = DEF_XW + DEF_YW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_COUNT = DEPTH[CNTW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ca6_cos_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ca6_cos_sequencer
// Description : Host-side initiator for the Ca6 cosine accelerator. Buffers
//               (x, y) requests, issues them one at a time with a start
//               pulse, waits for done or a timeout, and returns the result.
// Revision    : 1.0 - initial release
// ============================================================================
module ca6_cos_sequencer
  import ca6_seq_pkg::*;
#(
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int CW      = DEF_CW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [CW-1:0] rsp_cos,
  output logic          rsp_err,
  output logic          acc_start,
  output logic [XW-1:0] acc_xin,
  output logic [YW-1:0] acc_yin,
  input  logic          acc_done,
  input  logic [CW-1:0] acc_cosx,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

  seq_state_t          state;
  logic [TW-1:0]       tmo_cnt;
  logic [XW+YW-1:0]    fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  // Head is popped in the ISSUE cycle; it was already latched on ISSUE entry
  assign fifo_pop  = (state == ISSUE);
  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  ca6_req_fifo #(
    .WIDTH (XW + YW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   ({req_x, req_y}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request sequencing FSM with registered accelerator and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      acc_start <= 1'b0;
      acc_xin   <= '0;
      acc_yin   <= '0;
      rsp_valid <= 1'b0;
      rsp_cos   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= ISSUE;
            acc_start <= 1'b1;
            acc_xin   <= fifo_head[XW+YW-1:YW];
            acc_yin   <= fifo_head[YW-1:0];
          end
        end
        ISSUE: begin
          // done in this cycle is ignored: the accelerator has only just started
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // done takes priority over an expiring timeout in the same cycle
          if (acc_done) begin
            rsp_cos   <= acc_cosx;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (tmo_cnt == TIMEOUT_CNT) begin
            rsp_cos   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
